// File: rtl/aes_decrypt_scheduler.sv
// Two-requester front end for one shared aes128_decrypt core.
// Round-robin grant, one operation in flight, per-operation timeout.
module aes_decrypt_scheduler #(
    parameter int TIMEOUT = 31
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [127:0] req_key0,
    input  logic [127:0] req_key1,
    input  logic [127:0] req_ct0,
    input  logic [127:0] req_ct1,
    output logic         core_rst_n,
    output logic [127:0] core_key,
    output logic [127:0] core_ciphertext,
    input  logic [127:0] core_plaintext,
    input  logic         core_done,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         out_id,
    output logic         out_err,
    output logic         busy
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_RESP
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic           r_last_grant;
    logic           r_id;
    logic           r_err;
    logic [127:0]   r_key;
    logic [127:0]   r_ct;
    logic [127:0]   r_data;
    logic [CW-1:0]  r_cnt;
    logic           w_grant;
    logic           w_accept;
    logic           w_done_ok;
    logic           w_timeout;

    always_comb begin
        w_grant = 1'b0;
        unique case (req_valid)
            2'b10:   w_grant = 1'b1;
            2'b11:   w_grant = ~r_last_grant;
            default: w_grant = 1'b0;
        endcase
    end

    // A done seen in the first RUN cycle is left over from the last job.
    assign w_done_ok = core_done && (r_cnt != '0);
    assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

    always_comb begin
        w_next    = r_state;
        req_ready = 2'b00;
        w_accept  = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!rst) begin
                    req_ready = req_valid & (w_grant ? 2'b10 : 2'b01);
                end
                w_accept = |req_ready;
                if (w_accept) begin
                    w_next = S_LOAD;
                end
            end
            S_LOAD: w_next = S_RUN;
            S_RUN: begin
                if (w_done_ok || w_timeout) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_id         <= 1'b0;
            r_err        <= 1'b0;
            r_key        <= '0;
            r_ct         <= '0;
            r_data       <= '0;
            r_cnt        <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_key        <= w_grant ? req_key1 : req_key0;
                r_ct         <= w_grant ? req_ct1 : req_ct0;
                r_id         <= w_grant;
                r_last_grant <= w_grant;
            end
            if (r_state == S_LOAD) begin
                r_cnt <= '0;
            end else if (r_state == S_RUN) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == S_RUN) begin
                if (w_done_ok) begin
                    r_data <= core_plaintext;
                    r_err  <= 1'b0;
                end else if (w_timeout) begin
                    r_data <= '0;
                    r_err  <= 1'b1;
                end
            end
        end
    end

    assign core_rst_n      = !(rst || (r_state == S_LOAD));
    assign core_key        = r_key;
    assign core_ciphertext = r_ct;
    assign out_valid       = (r_state == S_RESP);
    assign out_data        = r_data;
    assign out_id          = r_id;
    assign out_err         = r_err;
    assign busy            = (r_state != S_IDLE);

endmodule

// File: tb/tb_aes_decrypt_scheduler.sv
// Directed bench for aes_decrypt_scheduler with a table-driven core model.
module tb_aes_decrypt_scheduler;

    localparam int TIMEOUT = 31;

    localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] C1 = 128'h3ad77bb40d7a3660a89ecaf32466ef97;
    localparam logic [127:0] P1 = 128'h6bc1bee22e409f96e93d7e117393172a;
    localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C2 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] P2 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] JUNK = 128'hbadbadbadbadbadbadbadbadbadbadba;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   req_valid;
    logic [1:0]   req_ready;
    logic [127:0] req_key0, req_key1, req_ct0, req_ct1;
    logic         core_rst_n;
    logic [127:0] core_key, core_ciphertext, core_plaintext;
    logic         core_done;
    logic         out_valid, out_ready;
    logic [127:0] out_data;
    logic         out_id, out_err, busy;

    int n_checks = 0;
    int n_fail   = 0;

    int m_cnt;
    int m_lat;
    bit never_en;
    bit stale_en;
    logic m_done;

    always #5 clk = ~clk;

    aes_decrypt_scheduler #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_key0(req_key0),
        .req_key1(req_key1),
        .req_ct0(req_ct0),
        .req_ct1(req_ct1),
        .core_rst_n(core_rst_n),
        .core_key(core_key),
        .core_ciphertext(core_ciphertext),
        .core_plaintext(core_plaintext),
        .core_done(core_done),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data(out_data),
        .out_id(out_id),
        .out_err(out_err),
        .busy(busy)
    );

    function automatic logic [127:0] lookup(input logic [127:0] k,
                                            input logic [127:0] c);
        if (k == K1 && c == C1) return P1;
        if (k == K2 && c == C2) return P2;
        return 128'hfeedfeedfeedfeedfeedfeedfeedfeed;
    endfunction

    // Core model: done m_lat cycles after restart; plaintext junk until then.
    always @(posedge clk) begin
        if (!core_rst_n) m_cnt <= 0;
        else if (m_cnt < 1000) m_cnt <= m_cnt + 1;
    end

    assign m_done = !never_en && (m_cnt >= m_lat);
    assign core_done = m_done || (stale_en && (m_cnt == 0 || !core_rst_n));
    assign core_plaintext = m_done ? lookup(core_key, core_ciphertext) : JUNK;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = 2'b11;
        repeat (2) @(negedge clk);
        chk("rst_ready", 128'(req_ready), 128'(2'b00));
        chk("rst_core_rst_n", 128'(core_rst_n), 128'(1'b0));
        chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("rst_busy", 128'(busy), 128'(1'b0));
        chk("rst_out_data", out_data, 128'h0);
        chk("rst_core_key", core_key, 128'h0);
        rst = 1'b0;
        req_valid = 2'b00;
        @(negedge clk);
        chk("rst_release_core_rst_n", 128'(core_rst_n), 128'(1'b1));
    endtask

    // Called on a negedge; returns on the LOAD negedge.
    task automatic issue(input logic [1:0] v, input logic [1:0] keep,
                         input logic [1:0] exp_rdy,
                         input logic [127:0] exp_key);
        req_valid = v;
        #1;
        chk("grant_ready", 128'(req_ready), 128'(exp_rdy));
        @(negedge clk);
        req_valid = keep;
        #1;
        chk("load_core_rst_n", 128'(core_rst_n), 128'(1'b0));
        chk("load_ready", 128'(req_ready), 128'(2'b00));
        chk("load_core_key", core_key, exp_key);
    endtask

    task automatic finish_resp(input logic exp_id, input logic [127:0] exp_data,
                               input logic exp_err, input int exp_cyc,
                               input int hold);
        int cyc;
        bit seen;
        cyc = 0;
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            if (out_valid) begin
                seen = 1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        if (!seen) chk("resp_wait_expired", 128'(0), 128'(1));
        chk("resp_latency", 128'(cyc), 128'(exp_cyc));
        chk("resp_id", 128'(out_id), 128'(exp_id));
        chk("resp_data", out_data, exp_data);
        chk("resp_err", 128'(out_err), 128'(exp_err));
        chk("resp_ready", 128'(req_ready), 128'(2'b00));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk("hold_valid", 128'(out_valid), 128'(1'b1));
            chk("hold_data", out_data, exp_data);
            chk("hold_id", 128'(out_id), 128'(exp_id));
            chk("hold_ready", 128'(req_ready), 128'(2'b00));
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk("post_hs_valid", 128'(out_valid), 128'(1'b0));
    endtask

    initial begin
        rst = 1'b1;
        req_valid = 2'b00;
        out_ready = 1'b0;
        req_key0 = K1;
        req_ct0  = C1;
        req_key1 = K2;
        req_ct1  = C2;
        m_lat = 1;
        never_en = 0;
        stale_en = 0;

        do_reset();

        issue(2'b01, 2'b00, 2'b01, K1);
        finish_resp(1'b0, P1, 1'b0, 3, 0);
        chk("idle_busy", 128'(busy), 128'(1'b0));

        do_reset();
        issue(2'b11, 2'b10, 2'b01, K1);
        finish_resp(1'b0, P1, 1'b0, 3, 10);
        issue(2'b11, 2'b00, 2'b10, K2);
        finish_resp(1'b1, P2, 1'b0, 3, 0);

        never_en = 1;
        issue(2'b11, 2'b00, 2'b01, K1);
        finish_resp(1'b0, 128'h0, 1'b1, TIMEOUT + 1, 0);
        never_en = 0;

        m_lat = TIMEOUT - 1;
        issue(2'b10, 2'b00, 2'b10, K2);
        finish_resp(1'b1, P2, 1'b0, TIMEOUT + 1, 0);

        m_lat = TIMEOUT;
        issue(2'b01, 2'b00, 2'b01, K1);
        finish_resp(1'b0, 128'h0, 1'b1, TIMEOUT + 1, 0);

        m_lat = 3;
        stale_en = 1;
        issue(2'b01, 2'b00, 2'b01, K1);
        finish_resp(1'b0, P1, 1'b0, 5, 0);
        stale_en = 0;

        m_lat = 10;
        issue(2'b10, 2'b00, 2'b10, K2);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        req_valid = 2'b01;
        @(negedge clk);
        chk("midrun_rst_ready", 128'(req_ready), 128'(2'b00));
        chk("midrun_rst_core_rst_n", 128'(core_rst_n), 128'(1'b0));
        chk("midrun_busy", 128'(busy), 128'(1'b0));
        chk("midrun_out_valid", 128'(out_valid), 128'(1'b0));
        chk("midrun_core_key", core_key, 128'h0);
        rst = 1'b0;
        req_valid = 2'b00;
        @(negedge clk);
        chk("midrun_idle_valid", 128'(out_valid), 128'(1'b0));
        m_lat = 1;
        issue(2'b01, 2'b00, 2'b01, K1);
        finish_resp(1'b0, P1, 1'b0, 3, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
